// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the HighRISC multi-cycle controller: widths, opcodes,
// mux select codes, FSM states and the registered decode payload.
package multicycle_ctrl_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned FUNC_W  = 2;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned CLS_W   = 3;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_XORR = 4'd7,
    ALU_BEQ  = 4'd8,
    ALU_BNE  = 4'd9,
    ALU_BLT  = 4'd10,
    ALU_NOP  = 4'd11
  } op_mne;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } ctrl_state_t;

  typedef enum logic [CLS_W-1:0] {
    CLS_RTYPE, CLS_SET, CLS_MOV, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_NOP, CLS_HALT
  } instr_class_t;

  localparam logic [OP_W-1:0] OP_RTYPE0 = 3'b000;
  localparam logic [OP_W-1:0] OP_RTYPE1 = 3'b001;
  localparam logic [OP_W-1:0] OP_LOAD   = 3'b010;
  localparam logic [OP_W-1:0] OP_STORE  = 3'b011;
  localparam logic [OP_W-1:0] OP_SET    = 3'b100;
  localparam logic [OP_W-1:0] OP_BRANCH = 3'b101;
  localparam logic [OP_W-1:0] OP_MOV    = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT   = 3'b111;

  localparam logic [SEL_W-1:0] SEL_RF_RD    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_RF_ALT1  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_RF_ALT2  = 2'b10;
  localparam logic [SEL_W-1:0] SEL_RF_R15   = 2'b11;
  localparam logic [SEL_W-1:0] SEL_DATA_SET = 2'b00;
  localparam logic [SEL_W-1:0] SEL_DATA_MOV = 2'b01;
  localparam logic [SEL_W-1:0] SEL_DATA_ALU = 2'b10;
  localparam logic [SEL_W-1:0] SEL_DATA_MEM = 2'b11;

  typedef struct packed {
    instr_class_t       cls;
    op_mne              alu_op;
    logic [SEL_W-1:0]   data_sel;
    logic [SEL_W-1:0]   reg_sel;
    logic [SEL_W-1:0]   rd_sel;
  } decode_t;

endpackage

// File: rtl/multicycle_ctrl_instr_decode.sv
// Combinational instruction decoder: IR opcode/function/mov fields to
// instruction class, ALU operation and datapath mux selects.
module instr_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]    op_code,
  input  logic [FUNC_W-1:0]  func,
  input  logic               mov_func,
  output logic [CLS_W-1:0]   cls,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [SEL_W-1:0]   data_sel,
  output logic [SEL_W-1:0]   reg_sel,
  output logic [SEL_W-1:0]   rd_sel
);

  instr_class_t c;
  op_mne        a;

  always_comb begin
    c        = CLS_RTYPE;
    a        = ALU_ADD;
    data_sel = SEL_DATA_SET;
    reg_sel  = SEL_RF_RD;
    rd_sel   = SEL_RF_RD;
    unique case (op_code)
      OP_RTYPE0: begin
        data_sel = SEL_DATA_ALU;
        unique case (func)
          2'b00: a = ALU_ADD;
          2'b01: a = ALU_SUB;
          2'b10: a = ALU_AND;
          2'b11: a = ALU_OR;
        endcase
      end
      OP_RTYPE1: begin
        data_sel = SEL_DATA_ALU;
        unique case (func)
          2'b00: a = ALU_XOR;
          2'b01: a = ALU_SRL;
          2'b10: a = ALU_SLL;
          2'b11: a = ALU_XORR;
        endcase
      end
      OP_LOAD: begin
        c        = CLS_LOAD;
        reg_sel  = SEL_RF_R15;
        data_sel = SEL_DATA_MEM;
      end
      OP_STORE: c = CLS_STORE;
      OP_SET: begin
        c       = CLS_SET;
        reg_sel = SEL_RF_ALT1;
      end
      OP_BRANCH: begin
        c = CLS_BRANCH;
        unique case (func)
          2'b00: a = ALU_BEQ;
          2'b01: a = ALU_BNE;
          2'b10: a = ALU_BLT;
          2'b11: begin
            c = CLS_NOP;
            a = ALU_NOP;
          end
        endcase
      end
      OP_MOV: begin
        c        = CLS_MOV;
        data_sel = SEL_DATA_MOV;
        reg_sel  = mov_func ? SEL_RF_ALT1 : SEL_RF_ALT2;
        rd_sel   = mov_func ? SEL_RF_ALT1 : SEL_RF_ALT2;
      end
      OP_HALT: c = CLS_HALT;
    endcase
  end

  assign cls    = c;
  assign alu_op = a;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle HighRISC control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// bounded data-memory wait, HALT/Start/Ack handshake and a sticky fault state.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [OP_W-1:0]    op_code,
  input  logic [FUNC_W-1:0]  func,
  input  logic               movFunc,
  input  logic               mem_ready,
  output logic               Branch,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               mem_req,
  output logic [SEL_W-1:0]   dataSelect,
  output logic [SEL_W-1:0]   regSelect,
  output logic [SEL_W-1:0]   readRegSelect,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Ack,
  output logic               fault
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  ctrl_state_t        state, state_nxt;
  decode_t            dec_q, dec_d;
  logic [CNT_W-1:0]   wait_cnt;
  logic               timeout_hit;
  logic               drive_dp;

  logic [CLS_W-1:0]   dec_cls;
  logic [ALUOP_W-1:0] dec_alu;

  instr_decode u_decode (
    .op_code  (op_code),
    .func     (func),
    .mov_func (movFunc),
    .cls      (dec_cls),
    .alu_op   (dec_alu),
    .data_sel (dec_d.data_sel),
    .reg_sel  (dec_d.reg_sel),
    .rd_sel   (dec_d.rd_sel)
  );

  assign dec_d.cls    = instr_class_t'(dec_cls);
  assign dec_d.alu_op = op_mne'(dec_alu);

  // The last allowed empty MEM cycle is the one where the count would reach TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      dec_q    <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) dec_q <= dec_d;
      // MEM is only ever entered from EXEC, so clearing there clears on entry.
      if (state == S_EXEC) begin
        wait_cnt <= '0;
      end else if (state == S_MEM && !mem_ready && wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    Branch        = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    PCWrite       = 1'b0;
    IRWrite       = 1'b0;
    mem_req       = 1'b0;
    Ack           = 1'b0;
    fault         = 1'b0;
    dataSelect    = '0;
    regSelect     = '0;
    readRegSelect = '0;
    ALUOp         = '0;
    drive_dp      = 1'b0;
    unique case (state)
      S_IDLE: if (Start) state_nxt = S_FETCH;
      S_FETCH: begin
        IRWrite   = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = (dec_d.cls == CLS_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        drive_dp = 1'b1;
        unique case (dec_q.cls)
          CLS_LOAD, CLS_STORE: state_nxt = S_MEM;
          CLS_BRANCH: begin
            Branch    = 1'b1;
            PCWrite   = 1'b1;
            state_nxt = S_FETCH;
          end
          CLS_NOP: begin
            PCWrite   = 1'b1;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        drive_dp = 1'b1;
        mem_req  = 1'b1;
        MemRead  = (dec_q.cls == CLS_LOAD);
        MemWrite = (dec_q.cls == CLS_STORE);
        // A completing access takes priority over an expiring timeout.
        if (mem_ready) begin
          if (dec_q.cls == CLS_LOAD) begin
            state_nxt = S_WB;
          end else begin
            PCWrite   = 1'b1;
            state_nxt = S_FETCH;
          end
        end else if (timeout_hit) begin
          state_nxt = S_FAULT;
        end
      end
      S_WB: begin
        drive_dp  = 1'b1;
        RegWrite  = 1'b1;
        PCWrite   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        Ack = 1'b1;
        if (!Start) state_nxt = S_IDLE;
      end
      S_FAULT: fault = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
    if (drive_dp) begin
      ALUOp         = dec_q.alu_op;
      dataSelect    = dec_q.data_sel;
      regSelect     = dec_q.reg_sel;
      readRegSelect = dec_q.rd_sel;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus row queues the expected
// output vector for its cycle; a negedge monitor pops and compares.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  typedef struct packed {
    logic br, mrd, mwr, rw, pcw, irw, req, ack, flt;
    logic [1:0] ds, rs, rr;
    logic [3:0] alu;
  } outv_t;

  localparam logic [8:0] BR  = 9'b1_0000_0000;
  localparam logic [8:0] MRD = 9'b0_1000_0000;
  localparam logic [8:0] MWR = 9'b0_0100_0000;
  localparam logic [8:0] RW  = 9'b0_0010_0000;
  localparam logic [8:0] PCW = 9'b0_0001_0000;
  localparam logic [8:0] IRW = 9'b0_0000_1000;
  localparam logic [8:0] REQ = 9'b0_0000_0100;
  localparam logic [8:0] ACK = 9'b0_0000_0010;
  localparam logic [8:0] FLT = 9'b0_0000_0001;

  logic       Clk, Reset, Start, movFunc, mem_ready;
  logic [2:0] op_code;
  logic [1:0] func;
  logic       Branch, MemRead, MemWrite, RegWrite, PCWrite, IRWrite, mem_req, Ack, fault;
  logic [1:0] dataSelect, regSelect, readRegSelect;
  logic [3:0] ALUOp;

  outv_t got;
  outv_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    row_n = 0;

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .op_code(op_code), .func(func),
    .movFunc(movFunc), .mem_ready(mem_ready), .Branch(Branch), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .mem_req(mem_req), .dataSelect(dataSelect), .regSelect(regSelect),
    .readRegSelect(readRegSelect), .ALUOp(ALUOp), .Ack(Ack), .fault(fault)
  );

  assign got = {Branch, MemRead, MemWrite, RegWrite, PCWrite, IRWrite, mem_req, Ack, fault,
                dataSelect, regSelect, readRegSelect, ALUOp};

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic outv_t ov(input logic [8:0] s, input logic [1:0] ds, input logic [1:0] rs,
                               input logic [1:0] rr, input logic [3:0] alu);
    ov = {s, ds, rs, rr, alu};
  endfunction

  task automatic step(input logic rst, input logic st, input logic [2:0] op, input logic [1:0] fn,
                      input logic mv, input logic mr, input outv_t e);
    @(posedge Clk);
    #1;
    Reset = rst; Start = st; op_code = op; func = fn; movFunc = mv; mem_ready = mr;
    exp_q.push_back(e);
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      outv_t e;
      e = exp_q.pop_front();
      checks++;
      if (got !== e)  begin
        failures++;
        $display("FAIL outputs row=%0d actual=%b required=%b", row_n, got, e);
      end
      row_n++;
    end
  end

  initial begin
    outv_t z, ex_sub, wb_sub, ex_ld, mem_ld, wb_ld, ex_st, mem_st, memr_st;
    z       = '0;
    ex_sub  = ov(9'b0,    2'b10, 2'b00, 2'b00, ALU_SUB);
    wb_sub  = ov(RW|PCW,  2'b10, 2'b00, 2'b00, ALU_SUB);
    ex_ld   = ov(9'b0,    2'b11, 2'b11, 2'b00, ALU_ADD);
    mem_ld  = ov(MRD|REQ, 2'b11, 2'b11, 2'b00, ALU_ADD);
    wb_ld   = ov(RW|PCW,  2'b11, 2'b11, 2'b00, ALU_ADD);
    ex_st   = ov(9'b0,    2'b00, 2'b00, 2'b00, ALU_ADD);
    mem_st  = ov(MWR|REQ, 2'b00, 2'b00, 2'b00, ALU_ADD);
    memr_st = ov(MWR|REQ|PCW, 2'b00, 2'b00, 2'b00, ALU_ADD);

    Reset = 1'b1; Start = 1'b0; op_code = 3'b000; func = 2'b01; movFunc = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge Clk);

    // reset state, then R-type SUB
    step(0, 0, 3'b000, 2'b01, 0, 0, z);
    step(0, 1, 3'b000, 2'b01, 0, 0, z);
    step(0, 0, 3'b000, 2'b01, 0, 0, ov(IRW, 0, 0, 0, 0));
    step(0, 0, 3'b000, 2'b01, 0, 0, z);
    step(0, 0, 3'b000, 2'b01, 0, 0, ex_sub);
    step(0, 0, 3'b000, 2'b01, 0, 0, wb_sub);
    // load with three wait cycles
    step(0, 0, 3'b010, 2'b00, 0, 0, ov(IRW, 0, 0, 0, 0));
    step(0, 0, 3'b010, 2'b00, 0, 0, z);
    step(0, 0, 3'b010, 2'b00, 0, 0, ex_ld);
    step(0, 0, 3'b010, 2'b00, 0, 0, mem_ld);
    step(0, 0, 3'b010, 2'b00, 0, 0, mem_ld);
    step(0, 0, 3'b010, 2'b00, 0, 0, mem_ld);
    step(0, 0, 3'b010, 2'b00, 0, 1, mem_ld);
    step(0, 0, 3'b010, 2'b00, 0, 0, wb_ld);
    // BLT then branch-NOP
    step(0, 0, 3'b101, 2'b10, 0, 0, ov(IRW, 0, 0, 0, 0));
    step(0, 0, 3'b101, 2'b10, 0, 0, z);
    step(0, 0, 3'b101, 2'b10, 0, 0, ov(BR|PCW, 0, 0, 0, ALU_BLT));
    step(0, 0, 3'b101, 2'b11, 0, 0, ov(IRW, 0, 0, 0, 0));
    step(0, 0, 3'b101, 2'b11, 0, 0, z);
    step(0, 0, 3'b101, 2'b11, 0, 0, ov(PCW, 0, 0, 0, ALU_NOP));
    // set, MOV1, MOV2, XORR
    step(0, 0, 3'b100, 2'b00, 0, 0, ov(IRW, 0, 0, 0, 0));
    step(0, 0, 3'b100, 2'b00, 0, 0, z);
    step(0, 0, 3'b100, 2'b00, 0, 0, ov(9'b0,   2'b00, 2'b01, 2'b00, ALU_ADD));
    step(0, 0, 3'b100, 2'b00, 0, 0, ov(RW|PCW, 2'b00, 2'b01, 2'b00, ALU_ADD));
    step(0, 0, 3'b110, 2'b00, 0, 0, ov(IRW, 0, 0, 0, 0));
    step(0, 0, 3'b110, 2'b00, 0, 0, z);
    step(0, 0, 3'b110, 2'b00, 0, 0, ov(9'b0,   2'b01, 2'b10, 2'b10, ALU_ADD));
    step(0, 0, 3'b110, 2'b00, 0, 0, ov(RW|PCW, 2'b01, 2'b10, 2'b10, ALU_ADD));
    step(0, 0, 3'b110, 2'b00, 1, 0, ov(IRW, 0, 0, 0, 0));
    step(0, 0, 3'b110, 2'b00, 1, 0, z);
    step(0, 0, 3'b110, 2'b00, 1, 0, ov(9'b0,   2'b01, 2'b01, 2'b01, ALU_ADD));
    step(0, 0, 3'b110, 2'b00, 1, 0, ov(RW|PCW, 2'b01, 2'b01, 2'b01, ALU_ADD));
    step(0, 0, 3'b001, 2'b11, 0, 0, ov(IRW, 0, 0, 0, 0));
    step(0, 0, 3'b001, 2'b11, 0, 0, z);
    step(0, 0, 3'b001, 2'b11, 0, 0, ov(9'b0,   2'b10, 2'b00, 2'b00, ALU_XORR));
    step(0, 0, 3'b001, 2'b11, 0, 0, ov(RW|PCW, 2'b10, 2'b00, 2'b00, ALU_XORR));
    // store, immediate ready
    step(0, 0, 3'b011, 2'b00, 0, 0, ov(IRW, 0, 0, 0, 0));
    step(0, 0, 3'b011, 2'b00, 0, 0, z);
    step(0, 0, 3'b011, 2'b00, 0, 0, ex_st);
    step(0, 0, 3'b011, 2'b00, 0, 1, memr_st);
    // store, ready on the last cycle before timeout wins
    step(0, 0, 3'b011, 2'b00, 0, 0, ov(IRW, 0, 0, 0, 0));
    step(0, 0, 3'b011, 2'b00, 0, 0, z);
    step(0, 0, 3'b011, 2'b00, 0, 0, ex_st);
    step(0, 0, 3'b011, 2'b00, 0, 0, mem_st);
    step(0, 0, 3'b011, 2'b00, 0, 0, mem_st);
    step(0, 0, 3'b011, 2'b00, 0, 0, mem_st);
    step(0, 0, 3'b011, 2'b00, 0, 1, memr_st);
    // halt handshake
    step(0, 1, 3'b111, 2'b00, 0, 0, ov(IRW, 0, 0, 0, 0));
    step(0, 1, 3'b111, 2'b00, 0, 0, z);
    step(0, 1, 3'b111, 2'b00, 0, 0, ov(ACK, 0, 0, 0, 0));
    step(0, 0, 3'b111, 2'b00, 0, 0, ov(ACK, 0, 0, 0, 0));
    step(0, 0, 3'b011, 2'b00, 0, 0, z);
    step(0, 1, 3'b011, 2'b00, 0, 0, z);
    // store timeout into sticky fault, Start ignored, Reset exits
    step(0, 0, 3'b011, 2'b00, 0, 0, ov(IRW, 0, 0, 0, 0));
    step(0, 0, 3'b011, 2'b00, 0, 0, z);
    step(0, 0, 3'b011, 2'b00, 0, 0, ex_st);
    step(0, 0, 3'b011, 2'b00, 0, 0, mem_st);
    step(0, 0, 3'b011, 2'b00, 0, 0, mem_st);
    step(0, 0, 3'b011, 2'b00, 0, 0, mem_st);
    step(0, 0, 3'b011, 2'b00, 0, 0, mem_st);
    step(0, 1, 3'b011, 2'b00, 0, 0, ov(FLT, 0, 0, 0, 0));
    step(0, 1, 3'b011, 2'b00, 0, 1, ov(FLT, 0, 0, 0, 0));
    step(1, 0, 3'b011, 2'b00, 0, 0, ov(FLT, 0, 0, 0, 0));
    step(0, 1, 3'b010, 2'b00, 0, 0, z);
    // reset during a load wait, then a fresh start
    step(0, 0, 3'b010, 2'b00, 0, 0, ov(IRW, 0, 0, 0, 0));
    step(0, 0, 3'b010, 2'b00, 0, 0, z);
    step(0, 0, 3'b010, 2'b00, 0, 0, ex_ld);
    step(0, 0, 3'b010, 2'b00, 0, 0, mem_ld);
    step(1, 0, 3'b010, 2'b00, 0, 0, mem_ld);
    step(0, 0, 3'b111, 2'b00, 0, 0, z);
    step(0, 1, 3'b111, 2'b00, 0, 0, z);
    step(0, 1, 3'b111, 2'b00, 0, 0, ov(IRW, 0, 0, 0, 0));
    step(0, 0, 3'b111, 2'b00, 0, 0, z);
    step(0, 0, 3'b111, 2'b00, 0, 0, ov(ACK, 0, 0, 0, 0));
    step(0, 0, 3'b111, 2'b00, 0, 0, z);

    repeat (3) @(posedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the HighRISC core, replacing the single-cycle combinational decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, and waits on a data-memory ready handshake with a bounded timeout. It adds a HALT opcode with a Start/Ack program handshake and a sticky fault. It sits between the instruction register / data memory and the datapath muxes, ALU, register file and PC.

## Interface
- OP_W, 3: opcode width
- FUNC_W, 2: function-field width
- ALUOP_W, 4: ALU operation code width
- SEL_W, 2: width of every mux select
- TIMEOUT, 16: max consecutive MEM cycles without mem_ready before fault; 0 disables the timeout

Ports:
- Clk  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-high; single clock domain
- Start  in  1  begin program execution
- op_code  in  OP_W  IR opcode field
- func  in  FUNC_W  IR function field
- movFunc  in  1  IR mov select (0 MOV1, 1 MOV2)
- mem_ready  in  1  data memory completed the access
- Branch, MemRead, MemWrite, RegWrite, PCWrite, IRWrite  out  1  datapath strobes
- mem_req  out  1  data-memory request
- dataSelect, regSelect, readRegSelect  out  SEL_W  datapath mux selects
- ALUOp  out  ALUOP_W  ALU operation (op_mne encoding)
- Ack  out  1  program halted
- fault  out  1  memory timeout occurred; sticky

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- IDLE: all outputs 0. Start=1 → FETCH.
- FETCH: IRWrite=1 → DECODE.
- DECODE: register the decoded fields (class, ALUOp, selects, load/store).
  - op 111 → HALT.
  - Otherwise → EXEC.
- EXEC: ALUOp driven from the registered decode.
  - op 000: ADD/SUB/AND/OR by func 00..11.
  - op 001: XOR/SRL/SLL/XORR by func 00..11.
  - R-type, set (100), mov (110) → WB.
  - load (010), store (011) → MEM.
  - branch (101), func 00/01/10 = BEQ/BNE/BLT: Branch=1, PCWrite=1 → FETCH. Taken/not-taken is resolved by the PC logic from the ALU flag.
  - branch func 11: NOP. Branch=0, PCWrite=1 → FETCH.
- MEM: mem_req=1, plus MemRead (load) or MemWrite (store), held while waiting.
  - mem_ready=1: load → WB; store → PCWrite=1, → FETCH.
  - mem_ready=0: increment wait counter.
  - Counter reaching TIMEOUT with mem_ready still 0 → FAULT. mem_ready=1 on that same cycle wins over the timeout.
- WB: RegWrite=1, PCWrite=1 → FETCH. Selects per class:
  - R-type: regSelect 00, dataSelect 10.
  - set: regSelect 01, dataSelect 00.
  - MOV1: dataSelect 01, regSelect/readRegSelect 10.
  - MOV2: dataSelect 01, regSelect/readRegSelect 01.
  - load: write R15, regSelect 11, dataSelect 11.
- HALT: Ack=1. Start=0 → IDLE. Start held at 1 → remain in HALT.
- FAULT: fault=1, all strobes 0. Only Reset exits.
- Selects and ALUOp are 0 in every state other than EXEC/MEM/WB.

## Timing
- Reset: state=IDLE, wait counter=0, decode registers=0, every output 0. Reset mid-instruction (including mid-MEM) aborts the instruction the same cycle; mem_req drops on the next edge.
- Outputs are Moore: a function of state and the registered decode only. No combinational path from op_code/func/movFunc to any output.
- Cycles from FETCH to the next FETCH:
  - R/set/mov: 4
  - load: 5 + waits
  - store: 4 + waits
  - branch: 3
  - halt reaches HALT 2 cycles after FETCH.
- Wait counter: width $clog2(TIMEOUT+1). Cleared on MEM entry and on Reset; saturates, never wraps.
- Start is level-sensitive in IDLE and HALT, ignored in every other state.

## Structure
- Definitions package gains:
  - ctrl_state_t enum.
  - Opcode constants OP_RTYPE0 … OP_HALT (111).
  - Select constants SEL_RF_R15=2'b11, SEL_DATA_MEM=2'b11.
- Existing op_mne enum is reused for ALUOp.
- One combinational sub-module, instr_decode: op_code/func/movFunc → class, ALUOp, selects.
- multicycle_ctrl holds the FSM, decode registers and wait counter.

## Test plan
- Reset, Start=1, op=000 func=01 → IRWrite at cycle 1, ALUOp=SUB at cycle 3, RegWrite=1 dataSelect=10 at cycle 4, FETCH at cycle 5.
- Load (010), mem_ready low for 3 cycles then high → MemRead/mem_req high for 4 cycles, then WB with regSelect=11 dataSelect=11, no fault.
- TIMEOUT=4, store with mem_ready stuck 0 → FAULT after 4 MEM cycles, fault=1, MemWrite=0; fault stays 1 until Reset.
- Branch func 10 → ALUOp=BLT, Branch=1, PCWrite=1 in EXEC only. Branch func 11 → Branch=0, PCWrite=1.
- Op 111 → Ack=1 held while Start=1; Start→0 → IDLE next cycle, Ack=0.
- Reset asserted during MEM wait → next cycle IDLE, all outputs 0. Start → fresh FETCH.
